mux_rr_scheduler: RTL and testbench

//   Shares one WIDTH-bit operand path among NUM_INPUTS requesters, e.g. matrix row streams feeding
//   one floating-point MAC. Round-robin arbitration grants one requester per burst, and a burst ends
//   on a beat flagged last. Beats from the granted requester are routed through the packed-slice

---
 rtl/mux_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_mux_rr_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin, burst-locked N:1 beat multiplexer.
// One requester is granted per burst. Its beats are steered from the packed
// request bus, where requester 0 occupies the MSB slice, into a single-entry
// valid/ready output register. A burst closes on a beat flagged last. Each
// arbitration costs one idle bubble cycle.
module mux_rr_scheduler #(
    parameter int WIDTH      = 32,
    parameter int NUM_INPUTS = 4,
    localparam int SEL_W     = $clog2(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS-1:0]       req_valid,
    input  logic [NUM_INPUTS-1:0]       req_last,
    input  logic [NUM_INPUTS*WIDTH-1:0] req_data,
    output logic [NUM_INPUTS-1:0]       req_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_last,
    output logic                        busy,
    output logic [SEL_W-1:0]            grant_idx
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_grant;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_sel;
    logic               r_out_last;

    logic               w_locked;
    logic               w_load_en;
    logic               w_valid_g;
    logic               w_last_g;
    logic               w_xfer;
    logic               w_found;
    logic [SEL_W-1:0]   w_winner;
    logic [WIDTH-1:0]   w_slice;

    // (base + ofs) reduced modulo NUM_INPUTS; both operands are below NUM_INPUTS.
    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base,
                                                  input int unsigned      ofs);
        logic [SEL_W:0] sum;
        sum = {1'b0, base} + (SEL_W+1)'(ofs);
        sum = (sum >= (SEL_W+1)'(NUM_INPUTS)) ? (sum - (SEL_W+1)'(NUM_INPUTS)) : sum;
        return sum[SEL_W-1:0];
    endfunction

    assign w_locked  = (r_state == ST_LOCKED);
    assign w_load_en = ~r_out_valid | out_ready;
    assign w_valid_g = req_valid[r_grant];
    assign w_last_g  = req_last[r_grant];
    assign w_xfer    = w_locked & w_valid_g & w_load_en;

    // Round-robin pick: scan from the farthest candidate back to ptr so the nearest valid one wins.
    always_comb begin
        logic [SEL_W-1:0] v_idx;
        w_found  = 1'b0;
        w_winner = r_ptr;
        v_idx    = r_ptr;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            v_idx    = wrap_idx(r_ptr, k);
            w_found  = w_found | req_valid[v_idx];
            w_winner = req_valid[v_idx] ? v_idx : w_winner;
        end
    end

    // Steer the granted requester's slice; requester i lives at the i-th slice counted from the MSB.
    always_comb begin
        w_slice = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            w_slice = (r_grant == SEL_W'(i)) ? req_data[(NUM_INPUTS-1-i)*WIDTH +: WIDTH] : w_slice;
        end
    end

    // Only the granted requester may be ready, and only when the output register can take a beat.
    always_comb begin
        req_ready = '0;
        if (w_locked) begin
            req_ready[r_grant] = w_load_en;
        end else begin
            req_ready = '0;
        end
    end

    // Arbitration FSM: IDLE picks a winner (bubble cycle), LOCKED holds it until a last beat moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer && w_last_g) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= (r_grant == SEL_W'(NUM_INPUTS - 1)) ? '0 : r_grant + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-entry output stage: load on transfer, empty when drained with nothing new arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_slice;
            r_out_sel   <= r_grant;
            r_out_last  <= w_last_g;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_last  = r_out_last;
    assign busy      = w_locked;
    assign grant_idx = r_grant;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed and random bench for mux_rr_scheduler with a per-requester scoreboard.
module tb_mux_rr_scheduler;

    localparam int WIDTH = 32;
    localparam int NUM   = 4;
    localparam int SEL_W = 2;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM-1:0]        req_valid = '0;
    logic [NUM-1:0]        req_last = '0;
    logic [NUM*WIDTH-1:0]  req_data = '0;
    logic [NUM-1:0]        req_ready;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_last;
    logic                  busy;
    logic [SEL_W-1:0]      grant_idx;

    mux_rr_scheduler #(.WIDTH(WIDTH), .NUM_INPUTS(NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_pass = 0;
    int               n_fail = 0;
    beat_t            src_q [NUM][$];
    beat_t            exp_q [NUM][$];
    logic [NUM-1:0]   en = '1;
    logic             last_pushed [NUM];
    int               wait_cnt [NUM];
    logic [SEL_W-1:0] grant_log [$];
    logic             burst_open = 1'b0;
    logic [SEL_W-1:0] open_sel = '0;
    int               delivered = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic push_beat(input int i, input logic [WIDTH-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[i].push_back(b);
        exp_q[i].push_back(b);
        last_pushed[i] = l;
    endtask

    task automatic flush();
        for (int i = 0; i < NUM; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
            wait_cnt[i] = 0;
            last_pushed[i] = 1'b1;
        end
        grant_log.delete();
        burst_open = 1'b0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM; i++) begin
            if (src_q[i].size() > 0 && en[i]) begin
                req_valid[i] = 1'b1;
                req_last[i]  = src_q[i][0].last;
                req_data[(NUM-i)*WIDTH-1 -: WIDTH] = src_q[i][0].data;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
                req_data[(NUM-i)*WIDTH-1 -: WIDTH] = '0;
            end
        end
    endtask

    // One clock: sample handshakes before the edge, update sources and grant bookkeeping after it.
    task automatic cycle();
        logic [NUM-1:0] hs;
        logic [NUM-1:0] pre_valid;
        logic           pre_busy;
        beat_t          e;
        drive_inputs();
        #1;
        hs        = req_valid & req_ready;
        pre_valid = req_valid;
        pre_busy  = busy;
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        if (out_valid && out_ready) begin
            chk("sb_has_expected", 64'(exp_q[out_sel].size() != 0), 64'd1);
            if (exp_q[out_sel].size() != 0) begin
                e = exp_q[out_sel].pop_front();
                chk("sb_data", 64'(out_data), 64'(e.data));
                chk("sb_last", 64'(out_last), 64'(e.last));
            end
            if (burst_open) chk("no_interleave", 64'(out_sel), 64'(open_sel));
            burst_open = !out_last;
            open_sel   = out_sel;
            delivered++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM; i++) begin
            if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (busy && !pre_busy) begin
            grant_log.push_back(grant_idx);
            for (int i = 0; i < NUM; i++) begin
                if (SEL_W'(i) == grant_idx) begin
                    chk("fair_wait", 64'(wait_cnt[i] < NUM), 64'd1);
                    wait_cnt[i] = 0;
                end else if (pre_valid[i]) begin
                    wait_cnt[i]++;
                end
            end
        end
        drive_inputs();
        #1;
    endtask

    task automatic run_idle(input int budget);
        int k;
        int left;
        k = 0;
        left = 1;
        while (left != 0 && k < budget) begin
            cycle();
            k++;
            left = (out_valid || busy) ? 1 : 0;
            for (int i = 0; i < NUM; i++) if (src_q[i].size() > 0) left = 1;
        end
        chk("drain_in_budget", 64'(k < budget), 64'd1);
        left = 0;
        for (int i = 0; i < NUM; i++) left += exp_q[i].size();
        chk("sb_empty", 64'(left), 64'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5];
        int d0;
        flush();
        // ---- 1: reset values, then asynchronous reset mid-burst ----
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_grant",     64'(grant_idx), 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        push_beat(1, 32'h1111_0000, 1'b0);
        push_beat(1, 32'h1111_0001, 1'b0);
        push_beat(1, 32'h1111_0002, 1'b1);
        cycle();
        out_ready = 1'b0;
        cycle();
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data",  64'(out_data),  64'd0);
        chk("arst_out_sel",   64'(out_sel),   64'd0);
        chk("arst_out_last",  64'(out_last),  64'd0);
        chk("arst_busy",      64'(busy),      64'd0);
        chk("arst_grant",     64'(grant_idx), 64'd0);
        chk("arst_req_ready", 64'(req_ready), 64'd0);
        #3;
        rst_n = 1'b1;
        flush();
        drive_inputs();
        out_ready = 1'b1;
        push_beat(3, 32'h3333_0000, 1'b1);
        push_beat(0, 32'h0000_0000, 1'b1);
        cycle();
        chk("ptr0_grant", 64'(grant_idx), 64'd0);
        run_idle(50);
        chk("ptr0_log_n", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) chk("ptr0_then3", 64'(grant_log[1]), 64'd3);

        // ---- 2: requester 2 sends A,B,C ----
        push_beat(2, 32'hAAAA_000A, 1'b0);
        push_beat(2, 32'hBBBB_000B, 1'b0);
        push_beat(2, 32'hCCCC_000C, 1'b1);
        cycle();
        chk("t2_busy", 64'(busy), 64'd1);
        chk("t2_grant", 64'(grant_idx), 64'd2);
        chk("t2_req_ready", 64'(req_ready), 64'h4);
        cycle();
        chk("t2_a_valid", 64'(out_valid), 64'd1);
        chk("t2_a_data", 64'(out_data), 64'hAAAA_000A);
        chk("t2_a_sel", 64'(out_sel), 64'd2);
        chk("t2_a_last", 64'(out_last), 64'd0);
        cycle();
        chk("t2_b_data", 64'(out_data), 64'hBBBB_000B);
        chk("t2_b_last", 64'(out_last), 64'd0);
        chk("t2_b_busy", 64'(busy), 64'd1);
        cycle();
        chk("t2_c_data", 64'(out_data), 64'hCCCC_000C);
        chk("t2_c_last", 64'(out_last), 64'd1);
        chk("t2_c_sel", 64'(out_sel), 64'd2);
        chk("t2_c_busy", 64'(busy), 64'd0);
        cycle();
        chk("t2_drained", 64'(out_valid), 64'd0);

        // ---- 3: round robin with 1-beat bursts, including wrap 3 -> 0 ----
        push_beat(3, 32'h3333_0001, 1'b1);
        run_idle(50);
        grant_log.delete();
        push_beat(0, 32'h0000_0101, 1'b1);
        push_beat(0, 32'h0000_0102, 1'b1);
        push_beat(1, 32'h1111_0101, 1'b1);
        push_beat(2, 32'h2222_0101, 1'b1);
        push_beat(3, 32'h3333_0101, 1'b1);
        run_idle(100);
        exp_order = '{0, 1, 2, 3, 0};
        chk("rr_log_n", 64'(grant_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("rr_order", 64'(grant_log[k]), 64'(exp_order[k]));
        end

        // ---- 4: backpressure for 5 cycles mid-burst ----
        d0 = delivered;
        push_beat(1, 32'hD000_0000, 1'b0);
        push_beat(1, 32'hD000_0001, 1'b0);
        push_beat(1, 32'hD000_0002, 1'b0);
        push_beat(1, 32'hD000_0003, 1'b1);
        cycle();
        cycle();
        chk("bp_first", 64'(out_data), 64'hD000_0000);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_ready_low", 64'(req_ready[1]), 64'd0);
            chk("bp_hold_data", 64'(out_data), 64'hD000_0000);
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        run_idle(50);
        chk("bp_count", 64'(delivered - d0), 64'd4);

        // ---- 5: granted requester 1 drops valid while 0 and 2 wait ----
        grant_log.delete();
        push_beat(1, 32'hE000_0000, 1'b0);
        push_beat(1, 32'hE000_0001, 1'b0);
        push_beat(1, 32'hE000_0002, 1'b1);
        cycle();
        cycle();
        en[1] = 1'b0;
        push_beat(0, 32'h0000_0E00, 1'b1);
        push_beat(2, 32'h2222_0E00, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("hold_ready0", 64'(req_ready[0]), 64'd0);
            chk("hold_busy", 64'(busy), 64'd1);
            chk("hold_grant", 64'(grant_idx), 64'd1);
        end
        en[1] = 1'b1;
        run_idle(50);
        exp_order = '{1, 2, 0, 0, 0};
        chk("hold_log_n", 64'(grant_log.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < grant_log.size()) chk("hold_order", 64'(grant_log[k]), 64'(exp_order[k]));
        end

        // ---- 6: random traffic and backpressure ----
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < NUM; i++) begin
                if (src_q[i].size() < 3 && $urandom_range(0, 3) == 0)
                    push_beat(i, $urandom, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
            end
            out_ready = ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0;
            cycle();
        end
        for (int i = 0; i < NUM; i++) begin
            if (!last_pushed[i]) push_beat(i, $urandom, 1'b1);
        end
        out_ready = 1'b1;
        run_idle(2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
